// File: rtl/morse_key_sequencer.sv
// Morse key front end: times key presses, classifies dot/dash, collects up to
// five elements per symbol and hands the symbol to the decoder on valid/ready.
module morse_key_sequencer #(
    parameter int unsigned DOT_MAX    = 3,
    parameter int unsigned MIN_PRESS  = 1,
    parameter int unsigned GAP_CYCLES = 20,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic       send,
    input  logic       code_ready,
    output logic       code_valid,
    output logic [4:0] code_bits,
    output logic [2:0] code_len,
    output logic       code_overflow,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_GAP,
        S_REQ
    } state_e;

    localparam logic [CNT_W-1:0] DOT_MAX_C    = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] MIN_PRESS_C  = CNT_W'(MIN_PRESS);
    localparam logic [CNT_W-1:0] GAP_CYCLES_C = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);
    localparam logic [2:0]       MAX_LEN      = 3'd5;

    state_e           state_q, state_d;
    logic             button_q;
    logic             send_q;
    logic             armed_q;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [4:0]       bits_q, bits_d;
    logic [2:0]       len_q, len_d;
    logic             ovf_q, ovf_d;
    logic             pend_q, pend_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic             key_rise;
    logic             send_edge;
    logic             is_dash;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + ONE_C;
    endfunction

    // A key already held when reset is released must not look like a fresh
    // rise, so rises are only accepted once the key has been seen up.
    assign key_rise  = button & ~button_q & armed_q;
    assign send_edge = send & ~send_q;
    assign is_dash   = (press_cnt_q > DOT_MAX_C);

    // Next-state and datapath decisions for the key/gap/request sequencing.
    always_comb begin
        state_d     = state_q;
        press_cnt_d = press_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        bits_d      = bits_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        pend_d      = pend_q;

        case (state_q)
            S_IDLE: begin
                if (send_edge && (len_q != 3'd0)) begin
                    state_d = S_REQ;
                end else if (key_rise) begin
                    state_d     = S_PRESS;
                    press_cnt_d = ONE_C;
                end
            end

            S_PRESS: begin
                if (send_edge) begin
                    pend_d = 1'b1;
                end
                if (button) begin
                    press_cnt_d = sat_inc(press_cnt_q);
                end else if (press_cnt_q < MIN_PRESS_C) begin
                    // Glitch: drop it without touching the symbol.
                    gap_cnt_d = '0;
                    state_d   = (len_q != 3'd0) ? S_GAP : S_IDLE;
                end else begin
                    if (len_q < MAX_LEN) begin
                        bits_d = bits_q | ({4'b0000, is_dash} << len_q);
                        len_d  = len_q + 3'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    // A send edge on the release cycle itself still counts.
                    if (pend_q || send_edge) begin
                        state_d = S_REQ;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end
                end
            end

            S_GAP: begin
                if (send_edge) begin
                    state_d = S_REQ;
                end else if (gap_cnt_q >= GAP_CYCLES_C) begin
                    state_d = S_REQ;
                end else if (key_rise) begin
                    state_d     = S_PRESS;
                    press_cnt_d = ONE_C;
                    gap_cnt_d   = '0;
                end else if (!button) begin
                    gap_cnt_d = sat_inc(gap_cnt_q);
                end
            end

            S_REQ: begin
                if (valid_q && code_ready) begin
                    bits_d  = '0;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    pend_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        valid_d = (state_d == S_REQ);
        busy_d  = (state_d != S_IDLE);
    end

    // State, history and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            button_q    <= 1'b0;
            send_q      <= 1'b0;
            armed_q     <= ~button;
            press_cnt_q <= '0;
            gap_cnt_q   <= '0;
            bits_q      <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            pend_q      <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            button_q    <= button;
            send_q      <= send;
            armed_q     <= armed_q | ~button;
            press_cnt_q <= press_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            bits_q      <= bits_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            pend_q      <= pend_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    assign code_valid    = valid_q;
    assign code_bits     = bits_q;
    assign code_len      = len_q;
    assign code_overflow = ovf_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed bench for morse_key_sequencer with a queue-based scoreboard.
module tb_morse_key_sequencer;

    logic       clk;
    logic       rst;
    logic       button;
    logic       send;
    logic       code_ready;
    logic       code_valid;
    logic [4:0] code_bits;
    logic [2:0] code_len;
    logic       code_overflow;
    logic       busy;

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    typedef struct {
        logic [4:0] bits;
        logic [2:0] len;
        logic       ovf;
        int         rise;
        int         width;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic have_cur = 1'b0;
    logic in_valid = 1'b0;
    int   vwidth   = 0;

    morse_key_sequencer #(
        .DOT_MAX   (3),
        .MIN_PRESS (1),
        .GAP_CYCLES(20),
        .CNT_W     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .button       (button),
        .send         (send),
        .code_ready   (code_ready),
        .code_valid   (code_valid),
        .code_bits    (code_bits),
        .code_len     (code_len),
        .code_overflow(code_overflow),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to timestamp expected valid rises.
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input logic b, input logic s, input logic r = 1'b0);
        @(negedge clk);
        button = b;
        send   = s;
        rst    = r;
    endtask

    task automatic press(input int n);
        repeat (n) step(1'b1, 1'b0);
    endtask

    task automatic gap(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic expect_sym(input logic [4:0] b, input logic [2:0] l, input logic o,
                              input int rise, input int width);
        exp_t e;
        e.bits  = b;
        e.len   = l;
        e.ovf   = o;
        e.rise  = rise;
        e.width = width;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expected symbol per valid window and checks rise time,
    // held contents on every valid cycle, and the window length.
    always @(negedge clk) begin
        if (code_valid) begin
            if (!in_valid) begin
                in_valid = 1'b1;
                vwidth   = 0;
                if (exp_q.size() == 0) begin
                    have_cur = 1'b0;
                    nvec++;
                    nmis++;
                    $display("FAIL unexpected_valid: got valid=1 required 0 (cycle %0d)", cyc);
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                    chk("valid_rise_cycle", cyc, cur.rise);
                end
            end
            vwidth++;
            if (have_cur) begin
                chk("code_bits", {27'd0, code_bits}, {27'd0, cur.bits});
                chk("code_len", {29'd0, code_len}, {29'd0, cur.len});
                chk("code_overflow", {31'd0, code_overflow}, {31'd0, cur.ovf});
                chk("busy_in_req", {31'd0, busy}, 32'd1);
            end
        end else if (in_valid) begin
            in_valid = 1'b0;
            if (have_cur) chk("valid_width", vwidth, cur.width);
            have_cur = 1'b0;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        button     = 1'b0;
        send       = 1'b0;
        rst        = 1'b1;
        code_ready = 1'b1;

        // Reset state
        repeat (3) step(1'b0, 1'b0, 1'b1);
        chk("rst_valid", {31'd0, code_valid}, 32'd0);
        chk("rst_bits", {27'd0, code_bits}, 32'd0);
        chk("rst_len", {29'd0, code_len}, 32'd0);
        chk("rst_ovf", {31'd0, code_overflow}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        step(1'b0, 1'b0);

        // Dash, dot, dash then send with ready held high: 1-cycle pulse
        press(10); gap(10); press(2); gap(10); press(10); gap(2);
        step(1'b0, 1'b1);
        expect_sym(5'b00101, 3'd3, 1'b0, cyc + 1, 1);
        step(1'b0, 1'b0);
        gap(3);
        chk("s1_idle_len", {29'd0, code_len}, 32'd0);
        chk("s1_idle_busy", {31'd0, busy}, 32'd0);

        // Same symbol, decoder stalls for 6 cycles
        code_ready = 1'b0;
        press(10); gap(10); press(2); gap(10); press(10); gap(2);
        step(1'b0, 1'b1);
        expect_sym(5'b00101, 3'd3, 1'b0, cyc + 1, 7);
        repeat (6) step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        code_ready = 1'b1;
        gap(3);
        chk("s2_len_cleared", {29'd0, code_len}, 32'd0);
        chk("s2_valid_low", {31'd0, code_valid}, 32'd0);

        // Single dot then auto-send after the gap timeout
        press(2);
        step(1'b0, 1'b0);
        expect_sym(5'b00000, 3'd1, 1'b0, cyc + 1 + 21, 1);
        gap(30);
        chk("s3_idle_busy", {31'd0, busy}, 32'd0);

        // Six dots: sixth overflows
        repeat (6) begin
            press(2);
            gap(5);
        end
        step(1'b0, 1'b1);
        expect_sym(5'b00000, 3'd5, 1'b1, cyc + 1, 1);
        step(1'b0, 1'b0);
        gap(3);
        press(10); gap(3);
        step(1'b0, 1'b1);
        expect_sym(5'b00001, 3'd1, 1'b0, cyc + 1, 1);
        step(1'b0, 1'b0);
        gap(3);

        // Send with empty buffer is ignored
        step(1'b0, 1'b1);
        repeat (4) begin
            step(1'b0, 1'b0);
            chk("empty_send_valid", {31'd0, code_valid}, 32'd0);
            chk("empty_send_busy", {31'd0, busy}, 32'd0);
        end

        // Send during an 8-cycle press: valid right after release
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1);
        repeat (4) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        expect_sym(5'b00001, 3'd1, 1'b0, cyc + 1, 1);
        gap(4);

        // Reset in the middle of a press after two stored elements
        press(2); gap(3); press(2); gap(3);
        chk("s6_len_before_rst", {29'd0, code_len}, 32'd2);
        repeat (4) step(1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0);
        chk("midrst_valid", {31'd0, code_valid}, 32'd0);
        chk("midrst_bits", {27'd0, code_bits}, 32'd0);
        chk("midrst_len", {29'd0, code_len}, 32'd0);
        chk("midrst_ovf", {31'd0, code_overflow}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (4) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        gap(30);
        chk("post_rst_len", {29'd0, code_len}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Normal operation resumes after reset
        press(2); gap(2);
        step(1'b0, 1'b1);
        expect_sym(5'b00000, 3'd1, 1'b0, cyc + 1, 1);
        step(1'b0, 1'b0);
        gap(5);

        for (int i = 0; i < 100 && (exp_q.size() != 0 || in_valid); i++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/morse_key_sequencer.md
# morse_key_sequencer

Front-end controller for the Morse decode datapath. It times each key press on `button` and classifies it as a dot or a dash, then accumulates up to five elements into a symbol buffer. When the operator asserts `send`, or the inter-character gap expires, it presents the completed symbol to the letter decoder over a valid/ready handshake. It sits between the raw key/send inputs and the decoder that produces `letter`/`done`.

## Interface
Parameters:
- `DOT_MAX`, default 3: a press of at most this many high cycles is a dot; longer presses are dashes.
- `MIN_PRESS`, default 1: presses shorter than this many cycles are discarded as glitches.
- `GAP_CYCLES`, default 20: low cycles after the last release that trigger an automatic send.
- `CNT_W`, default 16: width of the press and gap counters; both saturate at all-ones.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `button`, in, 1: key input, already synchronous to `clk`; 1 means pressed.
- `send`, in, 1: end-of-character request, synchronous; acted on at its rising edge only.
- `code_ready`, in, 1: decoder accepts the symbol.
- `code_valid`, out, 1: a symbol is presented.
- `code_bits`, out, 5: element i is in bit i (bit 0 is the first element); 1 means dash. Unused bits are 0.
- `code_len`, out, 3: number of elements held, 0..5.
- `code_overflow`, out, 1: more than 5 elements were keyed into this symbol.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- Registered history: `button_q` and `send_q`.
  - Key rise is `button & ~button_q`.
  - Send edge is `send & ~send_q`.
- States: IDLE, PRESS, GAP, REQ.
- IDLE:
  - On key rise, go to PRESS with the press counter set to 1.
  - On send edge with `code_len`=0, ignore it.
  - On send edge with `code_len`>0, go to REQ.
- PRESS:
  - Each cycle with `button`=1, increment the press counter (saturating).
  - The first cycle with `button`=0 ends the press; N is the counter value.
  - If N < `MIN_PRESS`, discard the press. Go to GAP if `code_len`>0, otherwise IDLE.
  - Otherwise append the element: dash if N > `DOT_MAX`, else dot.
  - If `code_len`<5, write the element at index `code_len` and increment `code_len`.
  - If `code_len`=5, drop the element and set `code_overflow` (sticky until the symbol is accepted).
  - A send edge seen during PRESS sets `send_pend`. At release, after the append, go to REQ if `send_pend` is set; otherwise go to GAP with the gap counter cleared.
- GAP:
  - Each cycle with `button`=0, increment the gap counter.
  - Key rise: go to PRESS and clear the gap counter.
  - Send edge: go to REQ.
  - Gap counter reaches `GAP_CYCLES`: go to REQ (auto-send).
  - If a key rise and a send edge occur in the same cycle, the send wins; the press is ignored.
- REQ:
  - `code_valid`=1; `code_bits`, `code_len` and `code_overflow` are held stable.
  - The `button` and `send` inputs are ignored.
  - On `code_valid & code_ready`: clear `code_bits`, `code_len`, `code_overflow` and `send_pend`, then go to IDLE.
  - A key still held after the handshake is not counted; only a fresh rise starts a new press.
- Reset (`rst`=1, at any time including mid-press or mid-REQ), on the next edge:
  - State goes to IDLE.
  - All counters, `button_q`, `send_q` and `send_pend` go to 0.
  - `code_valid`=0, `code_bits`=0, `code_len`=0, `code_overflow`=0, `busy`=0.

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- Press of N high cycles: the element appears in `code_len`/`code_bits` on the edge after the first low sample.
- Send edge in GAP or IDLE: `code_valid` rises on the next edge.
- Send during a press: `code_valid` rises on the edge after the release sample.
- Auto-send: `code_valid` rises exactly `GAP_CYCLES`+1 edges after the first low sample of the last press.
- Handshake: `code_valid` falls on the edge after the cycle in which `code_ready`=1. The earliest a new press can be counted is the cycle after that.
- `code_ready` may be held high permanently, giving a 1-cycle valid pulse.

## Test plan
All scenarios use `DOT_MAX`=3, `MIN_PRESS`=1, `GAP_CYCLES`=20.
- Press 10 cycles, gap 10, press 2, gap 10, press 10, then pulse `send` with `code_ready`=1. Expect `code_valid` for 1 cycle with `code_bits`=5'b00101, `code_len`=3, `code_overflow`=0, then IDLE.
- Same symbol with `code_ready` low for 6 cycles. Expect outputs stable for all 6 cycles, then `code_valid` falls 1 cycle after `code_ready` rises and `code_len` returns to 0.
- One 2-cycle press, then idle. Expect `code_valid` exactly 21 edges after release, `code_bits`=0, `code_len`=1.
- Six 2-cycle presses separated by 5-cycle gaps, then send. Expect `code_len`=5, `code_bits`=0, `code_overflow`=1; the next symbol starts with `code_overflow`=0.
- Send edge with an empty buffer: `code_valid` stays 0. Send asserted mid-press on an 8-cycle press: `code_valid` rises 1 cycle after release with `code_bits`=1, `code_len`=1.
- Assert `rst` for 1 cycle in the middle of a 10-cycle press after 2 stored elements. Expect all outputs 0 on the next edge, and the remaining high cycles of that press are not counted.
